// File: rtl/proc_issuer_pkg.sv
// Shared types for the PE issuer: command, instruction and FSM encodings.
package proc_issuer_pkg;

  localparam int ADDR_W = 16;
  localparam int CNT_W  = 8;
  localparam int ID_W   = 4;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [ID_W-1:0]   cmd_id_t;

  typedef enum logic [1:0] {
    INSTR_NOP   = 2'd0,
    INSTR_LD    = 2'd1,
    INSTR_INFO  = 2'd2,
    INSTR_STORE = 2'd3
  } instr_op_e;

  typedef struct packed {
    logic [1:0]       op;
    logic [CNT_W-1:0] count;
  } instr_info_t;

  typedef struct packed {
    instr_op_e opc;
    addr_t     payload;
  } instr_t;

  typedef struct packed {
    addr_t            src0;
    addr_t            src1;
    addr_t            dst;
    logic [1:0]       op;
    logic [CNT_W-1:0] count;
    cmd_id_t          id;
  } cmd_t;

  typedef enum logic [3:0] {
    S_IDLE, S_EN, S_LD0, S_LD1, S_INFO, S_STORE, S_WAIT_FIN, S_ACK, S_DONE
  } iss_state_e;

endpackage

// File: rtl/proc_issuer_fifo.sv
// Command FIFO: DEPTH entries, extra pointer wrap bit distinguishes full from empty.
module proc_cmd_fifo
  import proc_issuer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_push,
  input  cmd_t i_data,
  input  logic i_pop,
  output cmd_t o_data,
  output logic o_full,
  output logic o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0] wr_q, rd_q;
  cmd_t        mem_q [DEPTH];
  logic        do_push, do_pop;

  assign o_empty = (wr_q == rd_q);
  assign o_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  // A pop frees the slot this cycle, so a push while full is accepted alongside it.
  assign do_push = i_push && (!o_full || i_pop);
  assign do_pop  = i_pop && !o_empty;
  assign o_data  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PTR_ONE;
      if (do_pop)  rd_q <= rd_q + PTR_ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/proc_issuer.sv
// PE dispatch stage: pops commands and serialises EN, LD, LD, INFO, STORE, then acks finish.
// Optional watchdog on the finish wait is enabled by defining PROC_ISSUER_WDOG_EN.
module proc_issuer
  import proc_issuer_pkg::*;
#(
  parameter int CMD_DEPTH   = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic    i_clk,
  input  logic    i_rstn,
  input  logic    i_cmd_valid,
  output logic    o_cmd_ready,
  input  cmd_t    i_cmd,
  output logic    o_pe_en,
  output logic    o_pe_valid,
  output instr_t  o_pe_instr,
  input  logic    i_pe_busy,
  input  logic    i_pe_finish,
  output logic    o_done,
  output cmd_id_t o_done_id,
  output logic    o_idle,
  output logic    o_timeout
);

  iss_state_e  state_q, state_d;
  cmd_t        cmd_q, fifo_data;
  logic        fifo_full, fifo_empty, pop;
  instr_info_t info;

  assign o_cmd_ready = !fifo_full;
  assign pop         = (state_q == S_IDLE) && !fifo_empty && !i_pe_busy;
  assign o_idle      = fifo_empty && (state_q == S_IDLE);
  assign info        = '{op: cmd_q.op, count: cmd_q.count};

  proc_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_push  (i_cmd_valid && o_cmd_ready),
    .i_data  (i_cmd),
    .i_pop   (pop),
    .o_data  (fifo_data),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      if (pop) cmd_q <= fifo_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    o_pe_en    = 1'b0;
    o_pe_valid = 1'b0;
    o_pe_instr = '{opc: INSTR_NOP, payload: '0};
    o_done     = 1'b0;
    o_done_id  = '0;
    case (state_q)
      // Zero-length commands never touch the PE.
      S_IDLE:     if (pop) state_d = (fifo_data.count == '0) ? S_DONE : S_EN;
      S_EN:       begin o_pe_en = 1'b1; state_d = S_LD0; end
      S_LD0: begin
        o_pe_valid = 1'b1;
        o_pe_instr = '{opc: INSTR_LD, payload: cmd_q.src0};
        state_d    = S_LD1;
      end
      S_LD1: begin
        o_pe_valid = 1'b1;
        o_pe_instr = '{opc: INSTR_LD, payload: cmd_q.src1};
        state_d    = S_INFO;
      end
      S_INFO: begin
        o_pe_valid = 1'b1;
        o_pe_instr = '{opc: INSTR_INFO, payload: addr_t'(info)};
        state_d    = S_STORE;
      end
      S_STORE: begin
        o_pe_valid = 1'b1;
        o_pe_instr = '{opc: INSTR_STORE, payload: cmd_q.dst};
        state_d    = S_WAIT_FIN;
      end
      S_WAIT_FIN: if (i_pe_finish) state_d = S_ACK;
      S_ACK:      begin o_pe_valid = 1'b1; state_d = S_DONE; end
      S_DONE: begin
        o_done    = 1'b1;
        o_done_id = cmd_q.id;
        state_d   = S_IDLE;
      end
      default:    state_d = S_IDLE;
    endcase
  end

`ifdef PROC_ISSUER_WDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LIM  = WD_W'(TIMEOUT_CYC);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

  logic [WD_W-1:0] wd_cnt_q;
  logic            timeout_q;

  // Flag sets on the edge where the count reaches the limit; FSM keeps waiting regardless.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q == S_STORE)
        wd_cnt_q <= '0;
      else if (state_q == S_WAIT_FIN && wd_cnt_q != WD_LIM)
        wd_cnt_q <= wd_cnt_q + WD_ONE;
      if (state_q == S_WAIT_FIN && wd_cnt_q == WD_LAST)
        timeout_q <= 1'b1;
    end
  end

  assign o_timeout = timeout_q;
`else
  // Watchdog compiled out; the expression is constant 0 for any legal limit.
  assign o_timeout = (TIMEOUT_CYC < 0);
`endif

endmodule

// File: tb/tb_proc_issuer.sv
// Directed bench for proc_issuer: sequencing, FIFO backpressure, count==0, busy stall, watchdog, reset.
module tb_proc_issuer;
  import proc_issuer_pkg::*;

  logic    i_clk = 1'b0;
  logic    i_rstn = 1'b0;
  logic    i_cmd_valid = 1'b0;
  logic    i_pe_busy = 1'b0;
  logic    i_pe_finish = 1'b0;
  cmd_t    i_cmd = '0;
  logic    o_cmd_ready, o_pe_en, o_pe_valid, o_done, o_idle, o_timeout;
  instr_t  o_pe_instr;
  cmd_id_t o_done_id;

  int n_vec = 0;
  int n_err = 0;

  proc_issuer #(.CMD_DEPTH(2), .TIMEOUT_CYC(16)) dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_cmd_valid (i_cmd_valid),
    .o_cmd_ready (o_cmd_ready),
    .i_cmd       (i_cmd),
    .o_pe_en     (o_pe_en),
    .o_pe_valid  (o_pe_valid),
    .o_pe_instr  (o_pe_instr),
    .i_pe_busy   (i_pe_busy),
    .i_pe_finish (i_pe_finish),
    .o_done      (o_done),
    .o_done_id   (o_done_id),
    .o_idle      (o_idle),
    .o_timeout   (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #2;
  endtask

  function automatic logic [17:0] ei(input logic [1:0] opc, input logic [15:0] p);
    return {opc, p};
  endfunction

  function automatic cmd_t mkc(input logic [3:0] id, input logic [15:0] s0, input logic [15:0] s1,
                               input logic [15:0] d, input logic [1:0] op, input logic [7:0] cnt);
    cmd_t c;
    c.src0 = s0; c.src1 = s1; c.dst = d; c.op = op; c.count = cnt; c.id = id;
    return c;
  endfunction

  task automatic push1(input cmd_t c);
    i_cmd = c;
    i_cmd_valid = 1'b1;
    cyc();
    i_cmd_valid = 1'b0;
  endtask

  // Starts in the pop cycle; ends in the DONE cycle.
  task automatic exec(input cmd_t c, input int fin_dly);
    cyc(); chk("en", o_pe_en, 1); chk("en_valid", o_pe_valid, 0);
    cyc(); chk("ld0_valid", o_pe_valid, 1); chk("ld0", o_pe_instr, ei(2'd1, c.src0)); chk("ld0_en", o_pe_en, 0);
    cyc(); chk("ld1", o_pe_instr, ei(2'd1, c.src1));
    cyc(); chk("info", o_pe_instr, ei(2'd2, {6'd0, c.op, c.count}));
    cyc(); chk("store", o_pe_instr, ei(2'd3, c.dst)); chk("store_valid", o_pe_valid, 1);
    cyc();
    for (int i = 1; i < fin_dly; i++) begin
      chk("wait_valid", o_pe_valid, 0);
      cyc();
    end
    chk("wait_done", o_done, 0);
    i_pe_finish = 1'b1;
    cyc(); chk("ack_valid", o_pe_valid, 1); chk("ack_nop", o_pe_instr, 0); chk("ack_done", o_done, 0);
    i_pe_finish = 1'b0;
    cyc(); chk("done", o_done, 1); chk("done_id", o_done_id, c.id);
  endtask

  initial begin
    cmd_t c;

    // Reset state
    repeat (2) @(posedge i_clk);
    #2;
    chk("rst_ready", o_cmd_ready, 1); chk("rst_idle", o_idle, 1); chk("rst_en", o_pe_en, 0);
    chk("rst_valid", o_pe_valid, 0); chk("rst_instr", o_pe_instr, 0); chk("rst_done", o_done, 0);
    chk("rst_timeout", o_timeout, 0);
    @(posedge i_clk); #1 i_rstn = 1'b1; #1;

    // Basic sequence, finish 7 cycles after STORE
    c = mkc(4'd3, 16'h0010, 16'h0040, 16'h0080, 2'd0, 8'd10);
    push1(c);
    chk("t1_idle_busy", o_idle, 0);
    exec(c, 7);
    cyc(); chk("t1_done_clr", o_done, 0); chk("t1_idle", o_idle, 1);

    // Back-to-back pushes fill the FIFO while the first command runs
    i_cmd = mkc(4'd1, 16'h0100, 16'h0101, 16'h0102, 2'd1, 8'd4); i_cmd_valid = 1'b1;
    cyc();
    i_cmd = mkc(4'd2, 16'h0200, 16'h0201, 16'h0202, 2'd0, 8'd5);
    cyc(); chk("t3_en1", o_pe_en, 1); chk("t3_ready_a", o_cmd_ready, 1);
    i_cmd = mkc(4'd3, 16'h0300, 16'h0301, 16'h0302, 2'd1, 8'd6);
    cyc(); chk("t3_full", o_cmd_ready, 0); chk("t3_ld0", o_pe_instr, ei(2'd1, 16'h0100));
    i_cmd = mkc(4'd9, 16'h0900, 16'h0901, 16'h0902, 2'd0, 8'd1);
    cyc(); i_cmd_valid = 1'b0;
    chk("t3_ld1", o_pe_instr, ei(2'd1, 16'h0101));
    cyc(); cyc(); chk("t3_store", o_pe_instr, ei(2'd3, 16'h0102));
    cyc(); i_pe_finish = 1'b1;
    cyc(); i_pe_finish = 1'b0;
    cyc(); chk("t3_done1", o_done, 1); chk("t3_id1", o_done_id, 1); chk("t3_still_full", o_cmd_ready, 0);
    cyc(); exec(mkc(4'd2, 16'h0200, 16'h0201, 16'h0202, 2'd0, 8'd5), 1);
    cyc(); exec(mkc(4'd3, 16'h0300, 16'h0301, 16'h0302, 2'd1, 8'd6), 2);
    cyc(); chk("t3_idle", o_idle, 1); chk("t3_ready_end", o_cmd_ready, 1);

    // count==0 skips the PE
    push1(mkc(4'd5, 16'h0500, 16'h0501, 16'h0502, 2'd0, 8'd0));
    chk("t4_no_en_pop", o_pe_en, 0);
    cyc(); chk("t4_done", o_done, 1); chk("t4_id", o_done_id, 5); chk("t4_no_en", o_pe_en, 0);
    chk("t4_no_valid", o_pe_valid, 0);
    cyc(); chk("t4_done_clr", o_done, 0); chk("t4_idle", o_idle, 1);

    // Busy stalls the pop; matmul op forwarded unchanged
    i_pe_busy = 1'b1;
    c = mkc(4'd6, 16'h0600, 16'h0601, 16'h0602, 2'd2, 8'h20);
    push1(c);
    cyc(); chk("t5_stall_en", o_pe_en, 0); chk("t5_stall_idle", o_idle, 0);
    cyc(); chk("t5_stall_en2", o_pe_en, 0);
    i_pe_busy = 1'b0;
    exec(c, 3);
    cyc(); chk("t5_idle", o_idle, 1);

    // Watchdog
    c = mkc(4'd7, 16'h0700, 16'h0701, 16'h0702, 2'd3, 8'd2);
    push1(c);
`ifdef PROC_ISSUER_WDOG_EN
    repeat (6) cyc();
    for (int k = 1; k <= 16; k++) begin
      chk("t6_no_timeout", o_timeout, 0);
      cyc();
    end
    chk("t6_timeout", o_timeout, 1); chk("t6_still_wait", o_pe_valid, 0);
    i_pe_finish = 1'b1;
    cyc(); chk("t6_ack", o_pe_valid, 1);
    i_pe_finish = 1'b0;
    cyc(); chk("t6_done", o_done, 1); chk("t6_id", o_done_id, 7);
    cyc(); chk("t6_sticky", o_timeout, 1); chk("t6_idle", o_idle, 1);
    i_rstn = 1'b0; #1;
    chk("t6_rst_clr", o_timeout, 0);
    @(posedge i_clk); #1 i_rstn = 1'b1; #1;
`else
    exec(c, 20);
    cyc(); chk("t6_no_wdog", o_timeout, 0); chk("t6_idle", o_idle, 1);
`endif

    // Mid-operation reset drops the in-flight command
    push1(mkc(4'd8, 16'h0800, 16'h0801, 16'h0802, 2'd0, 8'd3));
    cyc(); cyc(); chk("t7_ld0", o_pe_valid, 1);
    i_rstn = 1'b0; #1;
    chk("t7_rst_valid", o_pe_valid, 0); chk("t7_rst_ready", o_cmd_ready, 1);
    chk("t7_rst_idle", o_idle, 1); chk("t7_rst_en", o_pe_en, 0);
    @(posedge i_clk); #1 i_rstn = 1'b1; #1;
    for (int k = 0; k < 3; k++) begin
      cyc(); chk("t7_no_done", o_done, 0); chk("t7_idle", o_idle, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
